// File: rtl/out_sched_pkg.sv
// out_sched_pkg: shared types, default sizes and parameter checks for the output write scheduler
package out_sched_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_HOLD = 8;
  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = $clog2(DEF_HOLD + 1);
  function automatic bit is_pow2(input int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/out_sched_fifo.sv
// out_sched_fifo: synchronous FIFO with flush; head is visible combinationally
module out_sched_fifo
  import out_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW = PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [PW:0]       level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("out_sched_fifo: DEPTH must be a power of 2 and >= 2");
  end
  // full blocks push even when a pop happens on the same edge
  assign full = level == (PW + 1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & !full & !flush;
  assign do_pop = pop & !empty & !flush;
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      wr <= wr + PW'(do_push);
      rd <= rd + PW'(do_pop);
      level <= level + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/out_write_scheduler.sv
// out_write_scheduler: buffers bridge stores and paces them to the output device
// Define OUT_SCHED_DEDUP_EN to silently drop a head value equal to the last issued one.
module out_write_scheduler
  import out_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic                     dev_write_en,
  output logic [DATA_W-1:0]        dev_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + 1) > CNT_W ? $clog2(HOLD_CYCLES + 1) : CNT_W;
  state_t state, state_nx;
  logic [CW-1:0] hold_cnt;
  logic [DATA_W-1:0] head;
  logic full, empty, pop, fire, dup;
  out_sched_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr_valid),
    .pop(pop),
    .flush(flush),
    .din(wr_data),
    .head(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
`ifdef OUT_SCHED_DEDUP_EN
  logic [DATA_W-1:0] last_issued;
  always_ff @(posedge clk) begin
    if (rst) last_issued <= '0;
    else if (fire) last_issued <= head;
  end
  assign dup = head == last_issued;
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  // state mirrors hold_cnt != 0, so it drops to IDLE on the edge the counter reaches zero
  always_comb begin
    state_nx = fire ? (HOLD_CYCLES > 1 ? HOLD : IDLE) : (hold_cnt <= CW'(1) ? IDLE : state);
  end
  always_comb begin
    pop = state == IDLE && !empty && !flush;
    fire = pop && !dup;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      dev_write_en <= 1'b0;
      dev_data <= '0;
    end else begin
      hold_cnt <= fire ? CW'(HOLD_CYCLES - 1) : hold_cnt != '0 ? hold_cnt - CW'(1) : '0;
      dev_write_en <= fire;
      if (fire) dev_data <= head;
    end
  end
  assign wr_ready = !full;
  assign busy = level != '0 || hold_cnt != '0;
endmodule

// File: tb/tb_out_write_scheduler.sv
// tb_out_write_scheduler: randomized and directed checks against a queue-based reference model
module tb_out_write_scheduler;
  localparam int DEPTH = 4;
  localparam int HOLD = 8;
`ifdef OUT_SCHED_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, wr_valid = 1'b0, flush = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, dev_write_en, busy;
  logic [31:0] dev_data;
  logic [2:0] level;
  int checks = 0, errors = 0;
  logic [31:0] m_q[$];
  int m_n = 0, m_next = 0;
  logic [31:0] m_last = '0, m_data = '0;
  logic m_we = 1'b0;
  logic [31:0] seen_v[$];
  int seen_t[$];
  wire [37:0] got = {dev_write_en, dev_data, level, wr_ready, busy};

  out_write_scheduler #(.DATA_W(32), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .dev_write_en(dev_write_en), .dev_data(dev_data), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: issue edge n is allowed once n >= m_next (last real issue + HOLD) and an older entry waits.
  function automatic logic [37:0] exp_vec();
    return {m_we, m_data, 3'(m_q.size()), 1'(m_q.size() < DEPTH), 1'(m_q.size() != 0 || m_n + 1 < m_next)};
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic f);
    bit acc;
    logic [31:0] h;
    rst = r; wr_valid = v; wr_data = d; flush = f;
    @(posedge clk);
    m_n++;
    if (r) begin
      m_q.delete(); m_we = 0; m_data = '0; m_last = '0; m_next = 0;
    end else if (f) begin
      m_q.delete(); m_we = 0;
    end else begin
      acc = v && m_q.size() < DEPTH;
      m_we = 0;
      if (m_q.size() != 0 && m_n >= m_next) begin
        h = m_q.pop_front();
        if (!(DEDUP && h == m_last)) begin
          m_we = 1; m_data = h; m_last = h; m_next = m_n + HOLD;
        end
      end
      if (acc) m_q.push_back(d);
    end
    #1;
    if (dev_write_en) begin seen_v.push_back(dev_data); seen_t.push_back(m_n); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 32'hdead, i == 1);
      checks++;
      if (got !== {1'b0, 32'h0, 3'd0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL reset edge=%0d got=%h exp=%h", m_n, got, {1'b0, 32'h0, 3'd0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_single();
    int e;
    seen_v.delete(); seen_t.delete();
    cyc(0, 1, 32'h11, 0);
    e = m_n;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc(0, 0, 0, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL single edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
    checks++;
    if (seen_v.size() != 1 || seen_v[0] !== 32'h11 || seen_t[0] != e + 1) begin
      errors++; $display("FAIL single_strobe count=%0d first_edge=%0d exp count=1 edge=%0d", seen_v.size(), seen_t.size() ? seen_t[0] : -1, e + 1);
    end
  endtask

  task automatic test_burst();
    logic [31:0] expv[$] = '{32'h1, 32'hA, 32'hB, 32'hC, 32'hD};
    cyc(1, 0, 0, 0);
    seen_v.delete(); seen_t.delete();
    for (int i = 0; i < 50; i++) begin
      cyc(0, i < 5, i < 5 ? expv[i] : 32'h0, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL burst edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
      if (i == 4) begin
        checks++;
        if (level !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL burst_full level=%0d ready=%b exp level=4 ready=0", level, wr_ready); end
      end
    end
    checks++;
    if (seen_v.size() != 5) begin errors++; $display("FAIL burst_count got=%0d exp=5", seen_v.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (seen_v[i] !== expv[i] || (i > 0 && seen_t[i] - seen_t[i-1] != HOLD)) begin
        errors++; $display("FAIL burst_order idx=%0d got=%h exp=%h gap=%0d", i, seen_v[i], expv[i], i > 0 ? seen_t[i] - seen_t[i-1] : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] k = 32'h50;
    logic rdy;
    int max_lvl = 0;
    cyc(1, 0, 0, 0);
    seen_v.delete(); seen_t.delete();
    for (int i = 0; i < 80; i++) begin
      rdy = wr_ready;
      cyc(0, i < 40, k, 0);
      if (i < 40 && rdy) k++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL backpressure edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
    checks++;
    if (max_lvl > DEPTH) begin errors++; $display("FAIL bp_level got=%0d exp<=%0d", max_lvl, DEPTH); end
    for (int i = 0; i < seen_v.size(); i++) begin
      checks++;
      if (seen_v[i] !== 32'h50 + i) begin errors++; $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, seen_v[i], 32'h50 + i); end
    end
  endtask

  task automatic test_flush();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h21 + i, 0);
    seen_v.delete(); seen_t.delete();
    cyc(0, 1, 32'h99, 1);
    checks++;
    if (level !== 3'd0 || dev_data !== 32'h21 || dev_write_en !== 1'b0) begin
      errors++; $display("FAIL flush level=%0d data=%h we=%b exp level=0 data=21 we=0", level, dev_data, dev_write_en);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, i == 3, 32'h25, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL flush_after edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
    checks++;
    if (seen_v.size() != 1 || seen_v[0] !== 32'h25) begin errors++; $display("FAIL flush_strobes count=%0d exp=1 value 25", seen_v.size()); end
  endtask

  task automatic test_rst_mid();
    int e;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 32'h31, 0);
    cyc(0, 1, 32'h32, 0);
    cyc(0, 1, 32'h33, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (got !== {1'b0, 32'h0, 3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL rst_mid got=%h exp=%h", got, {1'b0, 32'h0, 3'd0, 1'b1, 1'b0}); end
    seen_v.delete(); seen_t.delete();
    cyc(0, 1, 32'h7, 0);
    e = m_n;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL rst_after edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
    checks++;
    if (seen_v.size() != 1 || seen_v[0] !== 32'h7 || seen_t[0] != e + 1) begin errors++; $display("FAIL rst_issue count=%0d exp=1 at edge %0d", seen_v.size(), e + 1); end
  endtask

  task automatic test_dedup();
    logic [31:0] in_v[4] = '{32'h0, 32'h3, 32'h3, 32'h4};
    logic [31:0] expv[$];
    if (DEDUP) expv = '{32'h3, 32'h4}; else expv = '{32'h0, 32'h3, 32'h3, 32'h4};
    cyc(1, 0, 0, 0);
    seen_v.delete(); seen_t.delete();
    for (int i = 0; i < 45; i++) begin
      cyc(0, i < 4, i < 4 ? in_v[i] : 32'h0, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL dedup edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
    checks++;
    if (seen_v.size() != expv.size()) begin errors++; $display("FAIL dedup_count got=%0d exp=%0d", seen_v.size(), expv.size()); end
    else for (int i = 0; i < expv.size(); i++) begin
      checks++;
      if (seen_v[i] !== expv[i]) begin errors++; $display("FAIL dedup_val idx=%0d got=%h exp=%h", i, seen_v[i], expv[i]); end
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 1200; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom, $urandom_range(0, 39) == 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL random edge=%0d got=%h exp=%h", m_n, got, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_dedup();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
